// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC generation, in-order imem request/response tracking, instruction buffer and redirect flush.
// Define FETCH_PERF_CNT_EN to build the perf_fetch_o/perf_redir_o counters (tied to zero otherwise).
module fetch_ctrl #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2,
    parameter int unsigned     MAX_OUTST  = 2
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    input  logic            branch_en_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i,
    output logic [31:0]     perf_fetch_o,
    output logic [31:0]     perf_redir_o
);

    localparam int unsigned      CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned      PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned      PQ_W      = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] OUTST_LIM = CNT_W'(MAX_OUTST);
    localparam logic [PQ_W-1:0]  PQ_LAST   = PQ_W'(MAX_OUTST - 1);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PQ_W-1:0]  pq_wr_q, pq_wr_d;
    logic [PQ_W-1:0]  pq_rd_q, pq_rd_d;
    logic [PTR_W-1:0] fifo_wr_q, fifo_wr_d;
    logic [PTR_W-1:0] fifo_rd_q, fifo_rd_d;

    logic [XLEN-1:0]  pq_mem_q     [MAX_OUTST];
    logic [XLEN-1:0]  fifo_instr_q [FIFO_DEPTH];
    logic [XLEN-1:0]  fifo_pc_q    [FIFO_DEPTH];

    logic [CNT_W:0]   occupancy;
    logic             head_valid;
    logic             req;
    logic             rsp;
    logic             rsp_drop;
    logic             rsp_keep;
    logic             pop;
    logic [1:0]       unused_tgt_lsb;

    function automatic logic [PQ_W-1:0] pq_next(input logic [PQ_W-1:0] ptr);
        return (ptr == PQ_LAST) ? '0 : ptr + 1'b1;
    endfunction

    // Requests are throttled so every in-flight response is guaranteed a free buffer slot.
    assign occupancy  = {1'b0, outst_q} + {1'b0, count_q};
    assign head_valid = (count_q != '0);
    assign req        = resetn_i && !branch_en_i && (occupancy < DEPTH_LIM) && (outst_q < OUTST_LIM);

    // A response with nothing outstanding belongs to a request issued before reset and is ignored.
    assign rsp        = imem_rvalid_i && (outst_q != '0);
    assign rsp_drop   = rsp && (branch_en_i || (drop_q != '0));
    assign rsp_keep   = rsp && !rsp_drop;
    assign pop        = head_valid && instr_ready_i && !branch_en_i;

    assign unused_tgt_lsb = branch_target_i[1:0];

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path through this block can infer a latch.
        pc_d      = pc_q;
        outst_d   = outst_q;
        drop_d    = drop_q;
        count_d   = count_q;
        pq_wr_d   = pq_wr_q;
        pq_rd_d   = pq_rd_q;
        fifo_wr_d = fifo_wr_q;
        fifo_rd_d = fifo_rd_q;

        if (branch_en_i) begin
            pc_d = {branch_target_i[XLEN-1:2], 2'b00};
        end else if (req) begin
            pc_d = pc_q + XLEN'(4);
        end

        outst_d = outst_q + CNT_W'(req) - CNT_W'(rsp);

        // Every request still in flight after a redirect is wrong-path, including older dropped ones.
        if (branch_en_i) begin
            drop_d = outst_q - CNT_W'(rsp);
        end else if (rsp && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end

        if (req) begin
            pq_wr_d = pq_next(pq_wr_q);
        end
        if (rsp) begin
            pq_rd_d = pq_next(pq_rd_q);
        end

        if (branch_en_i) begin
            count_d   = '0;
            fifo_rd_d = fifo_wr_q;
        end else begin
            count_d = count_q + CNT_W'(rsp_keep) - CNT_W'(pop);
            if (rsp_keep) begin
                fifo_wr_d = fifo_wr_q + 1'b1;
            end
            if (pop) begin
                fifo_rd_d = fifo_rd_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            pc_q      <= RESET_PC;
            outst_q   <= '0;
            drop_q    <= '0;
            count_q   <= '0;
            pq_wr_q   <= '0;
            pq_rd_q   <= '0;
            fifo_wr_q <= '0;
            fifo_rd_q <= '0;
        end else begin
            pc_q      <= pc_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
            count_q   <= count_d;
            pq_wr_q   <= pq_wr_d;
            pq_rd_q   <= pq_rd_d;
            fifo_wr_q <= fifo_wr_d;
            fifo_rd_q <= fifo_rd_d;
        end
    end

    // NOTE: storage arrays are not reset; the pointers and counts alone decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (req) begin
            pq_mem_q[pq_wr_q] <= pc_q;
        end
        if (rsp_keep) begin
            fifo_instr_q[fifo_wr_q] <= imem_rdata_i;
            fifo_pc_q[fifo_wr_q]    <= pq_mem_q[pq_rd_q];
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = head_valid;
    assign instr_o       = head_valid ? fifo_instr_q[fifo_rd_q] : '0;
    assign instr_pc_o    = head_valid ? fifo_pc_q[fifo_rd_q] : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_redir_q;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            perf_fetch_q <= '0;
            perf_redir_q <= '0;
        end else begin
            if (pop) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (branch_en_i) begin
                perf_redir_q <= perf_redir_q + 32'd1;
            end
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_redir_o = perf_redir_q;
`else
    assign perf_fetch_o = '0;
    assign perf_redir_o = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: in-order imem responder with random latency, queue-based
// reference model compared every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_fetch_ctrl;

    localparam int D = 2;
    localparam int M = 2;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        resetn_i;
    logic        branch_en_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic [31:0] perf_fetch_o;
    logic [31:0] perf_redir_o;

    always #5 clk_i = ~clk_i;

    fetch_ctrl #(
        .XLEN       (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (D),
        .MAX_OUTST  (M)
    ) dut (
        .clk_i           (clk_i),
        .resetn_i        (resetn_i),
        .branch_en_i     (branch_en_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .instr_valid_o   (instr_valid_o),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .instr_ready_i   (instr_ready_i),
        .perf_fetch_o    (perf_fetch_o),
        .perf_redir_o    (perf_redir_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h0000_00A5;
    endfunction

    // Reference model: outstanding requests tagged wanted/unwanted, buffered entries, next PC.
    typedef struct { logic [31:0] pc; bit wanted; } out_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    out_t        m_out[$];
    ent_t        m_fifo[$];
    logic [31:0] m_pc = 32'h0;
    int unsigned m_perf_fetch = 0;
    int unsigned m_perf_redir = 0;

    // Memory environment: in-order responses, at most one per cycle, latency in [lat_min, lat_max].
    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t       pend[$];
    int          last_due = 0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          rdy_pct = 100;
    logic [31:0] req_log[$];
    int          req_seen = 0;

    task automatic cycle(input logic rst_n, input logic br, input logic [31:0] tgt, input logic rdy);
        pend_t p;
        out_t  o;
        ent_t  e;
        bit    m_req;
        bit    do_pop;
        int    d;

        resetn_i        = rst_n;
        branch_en_i     = br;
        branch_target_i = tgt;
        instr_ready_i   = rdy;
        imem_rvalid_i   = 1'b0;
        imem_rdata_i    = $urandom;
        if (!rst_n) begin
            pend.delete();
            last_due = cyc;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            p             = pend.pop_front();
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(p.addr);
        end

        @(negedge clk_i);
        m_req = rst_n && !br && (m_out.size() + m_fifo.size() < D) && (m_out.size() < M);
        check("imem_req", imem_req_o, m_req);
        if (m_req) check("imem_addr", imem_addr_o, m_pc);
        check("instr_valid", instr_valid_o, m_fifo.size() != 0);
        check("instr", instr_o, (m_fifo.size() != 0) ? m_fifo[0].instr : 32'h0);
        check("instr_pc", instr_pc_o, (m_fifo.size() != 0) ? m_fifo[0].pc : 32'h0);
        check("perf_fetch", perf_fetch_o, PERF_EN ? m_perf_fetch : 32'h0);
        check("perf_redir", perf_redir_o, PERF_EN ? m_perf_redir : 32'h0);

        if (imem_req_o === 1'b1) begin
            d = cyc + int'($urandom_range(lat_max, lat_min));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            p.addr   = imem_addr_o;
            p.due    = d;
            pend.push_back(p);
            req_log.push_back(imem_addr_o);
            req_seen++;
        end

        if (!rst_n) begin
            m_out.delete();
            m_fifo.delete();
            m_pc         = 32'h0;
            m_perf_fetch = 0;
            m_perf_redir = 0;
        end else begin
            do_pop = !br && rdy && (m_fifo.size() > 0);
            if (do_pop) begin
                e = m_fifo.pop_front();
                m_perf_fetch++;
            end
            if (imem_rvalid_i && m_out.size() > 0) begin
                o = m_out.pop_front();
                if (o.wanted && !br) begin
                    e.pc    = o.pc;
                    e.instr = mem_word(o.pc);
                    m_fifo.push_back(e);
                end
            end
            if (br) begin
                m_fifo.delete();
                foreach (m_out[i]) m_out[i].wanted = 1'b0;
                m_pc = {tgt[31:2], 2'b00};
                m_perf_redir++;
            end
            if (m_req) begin
                o.pc     = m_pc;
                o.wanted = 1'b1;
                m_out.push_back(o);
                m_pc = m_pc + 32'd4;
            end
        end

        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic rcycle(input int br_pct);
        logic        br;
        logic        rdy;
        logic [31:0] tgt;
        br  = ($urandom_range(99) < br_pct);
        rdy = ($urandom_range(99) < rdy_pct);
        tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
        cycle(1'b1, br, tgt, rdy);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    int  pops;
    bit  found;
    logic rdy_sel;
    int  pct_tab[6] = '{100, 70, 30, 100, 50, 90};

    initial begin
        resetn_i        = 1'b0;
        branch_en_i     = 1'b0;
        branch_target_i = 32'h0;
        imem_rvalid_i   = 1'b0;
        imem_rdata_i    = 32'h0;
        instr_ready_i   = 1'b0;
        @(posedge clk_i);
        #1;

        // Reset state
        do_reset(3);
        check("rst_req", imem_req_o, 32'h0);
        check("rst_valid", instr_valid_o, 32'h0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_pc", instr_pc_o, 32'h0);
        check("rst_perf_fetch", perf_fetch_o, 32'h0);
        check("rst_perf_redir", perf_redir_o, 32'h0);

        // Latency 1, ready=1: first valid two cycles after release, PC 0
        lat_min = 1; lat_max = 1;
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("first_not_yet", instr_valid_o, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("first_valid", instr_valid_o, 32'h1);
        check("first_pc", instr_pc_o, 32'h0);
        check("first_instr", instr_o, 32'h0000_00A5);
        repeat (20) cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // Decode stall: exactly FIFO_DEPTH requests, then resume
        do_reset(2);
        req_seen = 0;
        repeat (10) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("stall_reqs", req_seen, D);
        check("stall_full", instr_valid_o, 32'h1);
        repeat (20) cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // Redirect with two requests outstanding
        lat_min = 3; lat_max = 3;
        do_reset(2);
        req_seen = 0;
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("redir_outst", req_seen, 2);
        cycle(1'b1, 1'b1, 32'h100, 1'b1);
        check("redir_empty", instr_valid_o, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (instr_valid_o) found = 1'b1;
            else cycle(1'b1, 1'b0, 32'h0, 1'b0);
        end
        check("redir_seen", found, 32'h1);
        check("redir_first_pc", instr_pc_o, 32'h100);
        repeat (10) cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // Redirect coinciding with a response and a pop
        lat_min = 1; lat_max = 1;
        do_reset(2);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("coll_valid_before", instr_valid_o, 32'h1);
        cycle(1'b1, 1'b1, 32'h100, 1'b1);
        check("coll_flushed", instr_valid_o, 32'h0);
        branch_en_i = 1'b0;
        #1;
        check("coll_req", imem_req_o, 32'h1);
        check("coll_addr", imem_addr_o, 32'h100);
        repeat (10) cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // Back-to-back redirects: later target wins
        cycle(1'b1, 1'b1, 32'h200, 1'b1);
        cycle(1'b1, 1'b1, 32'h300, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (instr_valid_o) found = 1'b1;
            else cycle(1'b1, 1'b0, 32'h0, 1'b0);
        end
        check("b2b_seen", found, 32'h1);
        check("b2b_first_pc", instr_pc_o, 32'h300);
        repeat (10) cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // PC wrap (unaligned target bits ignored)
        cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        req_log.delete();
        repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap_first", (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("wrap_second", (req_log.size() > 1) ? req_log[1] : 32'hDEAD_BEEF, 32'h0);

        // Perf counters: 5 pops, 2 redirects
        do_reset(2);
        repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        pops = 0;
        for (int i = 0; i < 60 && pops < 5; i++) begin
            rdy_sel = instr_valid_o;
            if (rdy_sel) pops++;
            cycle(1'b1, 1'b0, 32'h0, rdy_sel);
        end
        check("perf_pops_done", pops, 5);
        cycle(1'b1, 1'b1, 32'h400, 1'b0);
        cycle(1'b1, 1'b1, 32'h500, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("perf_fetch_lit", perf_fetch_o, PERF_EN ? 32'd5 : 32'd0);
        check("perf_redir_lit", perf_redir_o, PERF_EN ? 32'd2 : 32'd0);

        // Random traffic
        for (int seg = 0; seg < 6; seg++) begin
            lat_min = 1;
            lat_max = 1 + (seg % 4);
            rdy_pct = pct_tab[seg];
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(399) == 0) do_reset(2);
                rcycle(5);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
